lif_scheduler: RTL

LIF_SCHEDULER -- requirements
Module: lif_scheduler

---
 rtl/lif_pkg.sv | 13 +
 rtl/lif_state_bank.sv | 45 ++++
 rtl/lif_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared types and default sizing for the time-multiplexed LIF neuron scheduler.
package lif_pkg;
  localparam int N_NEURONS_DEFAULT = 8;
  localparam int W_DEFAULT         = 8;
  localparam int STEP_CNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMMIT
  } lif_state_e;
endpackage

// File: rtl/lif_state_bank.sv
// Per-neuron membrane and input-current storage: one shared read index,
// one write port each for membrane and current, synchronous membrane clear.
module lif_state_bank
  import lif_pkg::*;
#(
  parameter  int N  = N_NEURONS_DEFAULT,
  parameter  int W  = W_DEFAULT,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_idx_i,
  output logic [W-1:0]  rd_mem_o,
  output logic [W-1:0]  rd_cur_o,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic [W-1:0]  mem_wdata_i,
  input  logic          mem_clr_i,
  input  logic          cur_we_i,
  input  logic [AW-1:0] cur_waddr_i,
  input  logic [W-1:0]  cur_wdata_i
);
  logic [W-1:0] mem_q [N];
  logic [W-1:0] cur_q [N];

  // NOTE: both arrays are plain flops with async reset because reset must zero every entry at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
        cur_q[i] <= '0;
      end
    end else begin
      if (mem_clr_i) begin
        for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else if (mem_we_i) begin
        mem_q[mem_waddr_i] <= mem_wdata_i;
      end
      if (cur_we_i) cur_q[cur_waddr_i] <= cur_wdata_i;
    end
  end

  assign rd_mem_o = mem_q[rd_idx_i];
  assign rd_cur_o = cur_q[rd_idx_i];
endmodule

// File: rtl/lif_scheduler.sv
// Sequences N_NEURONS neurons through one shared LIF datapath per timestep
// and publishes the resulting spike vector when the timestep completes.
module lif_scheduler
  import lif_pkg::*;
#(
  parameter  int N_NEURONS = N_NEURONS_DEFAULT,
  parameter  int W         = W_DEFAULT,
  localparam int AW        = $clog2(N_NEURONS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic                  cur_we,
  input  logic [AW-1:0]         cur_addr,
  input  logic [W-1:0]          cur_data,
  input  logic                  clr_state,
  output logic                  dp_valid,
  input  logic                  dp_ready,
  output logic [W-1:0]          dp_state,
  output logic [W-1:0]          dp_cur,
  input  logic                  dp_rvalid,
  input  logic [W-1:0]          dp_next,
  input  logic                  dp_spike,
  output logic [N_NEURONS-1:0]  spike_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [STEP_CNT_W-1:0] step_cnt
);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_NEURONS - 1);

  lif_state_e            state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic [N_NEURONS-1:0]  acc_q, acc_d;
  logic [N_NEURONS-1:0]  spike_q, spike_d;
  logic                  overrun_q, overrun_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic                  pend_clr_q, pend_clr_d;
  logic [W-1:0]          dps_q, dps_d;
  logic [W-1:0]          dpc_q, dpc_d;

  logic          mem_we, mem_clr, issue_entry;
  logic [AW-1:0] rd_idx;
  logic [W-1:0]  rd_mem, rd_cur;

  // The operands are captured on the edge that enters ISSUE, so they stay put
  // through a stall and a same-edge current write only lands for the next timestep.
  assign rd_idx = (state_q == WAIT) ? idx_q + AW'(1) : '0;

  lif_state_bank #(.N(N_NEURONS), .W(W)) u_bank (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (rd_idx),
    .rd_mem_o    (rd_mem),
    .rd_cur_o    (rd_cur),
    .mem_we_i    (mem_we),
    .mem_waddr_i (idx_q),
    .mem_wdata_i (dp_next),
    .mem_clr_i   (mem_clr),
    .cur_we_i    (cur_we),
    .cur_waddr_i (cur_addr),
    .cur_wdata_i (cur_data)
  );

  always_comb begin
    // NOTE: every _d defaults to its _q before the case, so no path can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    acc_d       = acc_q;
    spike_d     = spike_q;
    overrun_d   = overrun_q;
    step_cnt_d  = step_cnt_q;
    pend_clr_d  = pend_clr_q;
    dps_d       = dps_q;
    dpc_d       = dpc_q;
    mem_we      = 1'b0;
    mem_clr     = 1'b0;
    issue_entry = 1'b0;

    if (step && busy_q) overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        mem_clr = clr_state;
        if (step) begin
          idx_d       = '0;
          busy_d      = 1'b1;
          acc_d       = '0;
          state_d     = ISSUE;
          issue_entry = 1'b1;
        end
      end
      ISSUE: begin
        if (clr_state) pend_clr_d = 1'b1;
        if (dp_ready) state_d = WAIT;
      end
      WAIT: begin
        if (clr_state) pend_clr_d = 1'b1;
        if (dp_rvalid) begin
          mem_we        = 1'b1;
          acc_d[idx_q]  = dp_spike;
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
          end else begin
            idx_d       = idx_q + AW'(1);
            state_d     = ISSUE;
            issue_entry = 1'b1;
          end
        end
      end
      COMMIT: begin
        // A clear requested mid-timestep lands here, after the last writeback.
        mem_clr    = pend_clr_q | clr_state;
        pend_clr_d = 1'b0;
        spike_d    = acc_q;
        step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue_entry) begin
      dps_d = mem_clr ? '0 : rd_mem;
      dpc_d = rd_cur;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      acc_q      <= '0;
      spike_q    <= '0;
      overrun_q  <= 1'b0;
      step_cnt_q <= '0;
      pend_clr_q <= 1'b0;
      dps_q      <= '0;
      dpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      acc_q      <= acc_d;
      spike_q    <= spike_d;
      overrun_q  <= overrun_d;
      step_cnt_q <= step_cnt_d;
      pend_clr_q <= pend_clr_d;
      dps_q      <= dps_d;
      dpc_q      <= dpc_d;
    end
  end

  assign dp_valid  = (state_q == ISSUE);
  assign dp_state  = dps_q;
  assign dp_cur    = dpc_q;
  assign spike_out = spike_q;
  assign busy      = busy_q;
  assign done      = (state_q == COMMIT);
  assign overrun   = overrun_q;
  assign step_cnt  = step_cnt_q;
endmodule
